// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: shared ALU op encodings, BIST state encoding and LFSR taps. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   // Fibonacci taps 32,22,2,1 as bit positions 31,21,1,0
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

`default_nettype wire

// File: rtl/bist_lfsr.sv
// ---------------------------------------------------------------------------
// bist_lfsr: 32-bit Fibonacci LFSR, shift left, feedback into bit 0. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bist_lfsr
   import alu_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_1234
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        enable,
   output logic [31:0] value
);

   always_ff @(posedge clk) begin
      if (reset || load)
         value <= SEED;
      else if (enable)
         value <= {value[30:0], ^(value & LFSR_TAPS)};
   end

endmodule

`default_nettype wire

// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist: ALU built-in self-test engine; optional ALU_BIST_FIRST_FAIL_EN
// adds first-mismatch capture outputs. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_bist
   import alu_pkg::*;
#(
   parameter int          N           = 8,
   parameter int          NUM_VECTORS = 64,
   parameter logic [31:0] SEED        = 32'hACE1_1234,
   parameter int          FCW         = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   ALUResult,
   output logic [N-1:0]   SrcA,
   output logic [N-1:0]   SrcB,
   output logic [1:0]     ALUControl,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [FCW-1:0] fail_count
`ifdef ALU_BIST_FIRST_FAIL_EN
   ,
   output logic           first_fail_valid,
   output logic [15:0]    first_fail_index,
   output logic [1:0]     first_fail_op,
   output logic [N-1:0]   first_fail_expected,
   output logic [N-1:0]   first_fail_actual
`endif
);

   bist_state_t state;
   logic [15:0] index;
   logic [31:0] lfsr;
   logic [N-1:0] golden;
   logic start_accept;
   logic mismatch;
   logic last_vector;
   logic unused_lfsr;

   assign start_accept = start && (state == ST_IDLE || state == ST_DONE);
   assign mismatch     = (ALUResult != golden);
   assign last_vector  = (index == 16'(NUM_VECTORS - 1));
   assign unused_lfsr  = ^lfsr;

   bist_lfsr #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .load   (start_accept),
      .enable (state == ST_CHECK),
      .value  (lfsr)
   );

   always_comb begin
      golden = '0;
      case (ALUControl)
         ALU_ADD: golden = SrcA + SrcB;
         ALU_SUB: golden = SrcA - SrcB;
         ALU_AND: golden = SrcA & SrcB;
         ALU_OR:  golden = SrcA | SrcB;
         default: golden = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         SrcA       <= '0;
         SrcB       <= '0;
         ALUControl <= ALU_ADD;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_count <= '0;
         index      <= '0;
`ifdef ALU_BIST_FIRST_FAIL_EN
         first_fail_valid    <= 1'b0;
         first_fail_index    <= '0;
         first_fail_op       <= '0;
         first_fail_expected <= '0;
         first_fail_actual   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (state == ST_DONE) begin
                  done <= 1'b1;
                  pass <= (fail_count == '0);
               end
               // a new run overrides the DONE outputs set above
               if (start) begin
                  state      <= ST_DRIVE;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  fail_count <= '0;
                  index      <= '0;
`ifdef ALU_BIST_FIRST_FAIL_EN
                  first_fail_valid    <= 1'b0;
                  first_fail_index    <= '0;
                  first_fail_op       <= '0;
                  first_fail_expected <= '0;
                  first_fail_actual   <= '0;
`endif
               end
            end
            ST_DRIVE: begin
               SrcA       <= lfsr[N-1:0];
               SrcB       <= lfsr[16+N-1:16];
               ALUControl <= index[1:0];
               state      <= ST_CHECK;
            end
            ST_CHECK: begin
               if (mismatch && fail_count != '1)
                  fail_count <= fail_count + 1'b1;
`ifdef ALU_BIST_FIRST_FAIL_EN
               if (mismatch && !first_fail_valid) begin
                  first_fail_valid    <= 1'b1;
                  first_fail_index    <= index;
                  first_fail_op       <= ALUControl;
                  first_fail_expected <= golden;
                  first_fail_actual   <= ALUResult;
               end
`endif
               index <= index + 16'd1;
               if (last_vector) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_DRIVE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_bist.sv
// ---------------------------------------------------------------------------
// tb_alu_bist: scoreboard bench for alu_bist with correct, stuck-bit and
// all-zero ALU models. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_bist;

   localparam int N  = 8;
   localparam int NV = 64;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [1:0]   op;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   int   fault = 0;

   logic [N-1:0] alu_res, srca, srcb;
   logic [1:0]   ctl;
   logic         busy, done, pass;
   logic [15:0]  fcount;

   logic [N-1:0] srca2, srcb2;
   logic [1:0]   ctl2;
   logic         busy2, done2, pass2;
   logic [1:0]   fcount2;

`ifdef ALU_BIST_FIRST_FAIL_EN
   logic         ffv, ffv2;
   logic [15:0]  ffi, ffi2;
   logic [1:0]   ffop, ffop2;
   logic [N-1:0] ffe, ffe2, ffa, ffa2;
`endif

   int checks = 0;
   int failures = 0;
   vec_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [N-1:0] alu_ref(logic [N-1:0] a, logic [N-1:0] b, logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   assign alu_res = (fault == 1) ? (alu_ref(srca, srcb, ctl) | N'(1)) : alu_ref(srca, srcb, ctl);

   alu_bist #(.N(N), .NUM_VECTORS(NV), .SEED(32'hACE11234), .FCW(16)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUResult(alu_res),
      .SrcA(srca), .SrcB(srcb), .ALUControl(ctl),
      .busy(busy), .done(done), .pass(pass), .fail_count(fcount)
`ifdef ALU_BIST_FIRST_FAIL_EN
      , .first_fail_valid(ffv), .first_fail_index(ffi), .first_fail_op(ffop),
      .first_fail_expected(ffe), .first_fail_actual(ffa)
`endif
   );

   alu_bist #(.N(N), .NUM_VECTORS(NV), .SEED(32'hACE11234), .FCW(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .ALUResult('0),
      .SrcA(srca2), .SrcB(srcb2), .ALUControl(ctl2),
      .busy(busy2), .done(done2), .pass(pass2), .fail_count(fcount2)
`ifdef ALU_BIST_FIRST_FAIL_EN
      , .first_fail_valid(ffv2), .first_fail_index(ffi2), .first_fail_op(ffop2),
      .first_fail_expected(ffe2), .first_fail_actual(ffa2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent reference sequence: pushes the expected vectors for one run
   task automatic load_run(output int exp_fail, output int nonzero,
                           output int first_idx, output vec_t first_vec);
      logic [31:0] l;
      vec_t v;
      logic [N-1:0] r;
      l = 32'hACE11234;
      exp_fail = 0; nonzero = 0; first_idx = -1; first_vec = '0;
      sb.delete();
      for (int k = 0; k < NV; k++) begin
         v.a = l[N-1:0];
         v.b = l[16+N-1:16];
         v.op = 2'(k);
         sb.push_back(v);
         r = alu_ref(v.a, v.b, v.op);
         if (r != '0) nonzero++;
         if (r[0] == 1'b0) begin
            exp_fail++;
            if (first_idx < 0) begin
               first_idx = k;
               first_vec = v;
            end
         end
         l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      end
   endtask

   task automatic run(input int f, input bit inject);
      int exp_fail, nonzero, first_idx;
      vec_t first_vec, e, last;
      fault = f;
      load_run(exp_fail, nonzero, first_idx, first_vec);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         e = sb.pop_front();
         last = e;
         chk($sformatf("vec%0d", k), {srca, srcb, ctl}, e);
         if (k == 0) chk("vec0_directed", {srca, srcb, ctl}, {8'h34, 8'hE1, 2'b00});
         if (k == NV - 1) chk("busy_last", busy, 1);
         start = inject && (k == 5 || k == 25);
         @(negedge clk);
         start = 1'b0;
      end
      chk("busy_end", busy, 0);
      chk("done_not_yet", done, 0);
      @(negedge clk);
      chk("done", done, 1);
      chk("pass", pass, (exp_fail == 0 || f == 0) ? 1 : 0);
      chk("fail_count", fcount, (f == 1) ? exp_fail : 0);
      chk("hold_vector", {srca, srcb, ctl}, last);
      chk("sat_fail_count", fcount2, (nonzero > 3) ? 3 : nonzero);
      chk("sat_pass", pass2, 0);
      chk("sat_done", done2, 1);
`ifdef ALU_BIST_FIRST_FAIL_EN
      if (f == 1) begin
         chk("ff_valid", ffv, 1);
         chk("ff_index", ffi, first_idx);
         chk("ff_op", ffop, first_vec.op);
         chk("ff_expected", ffe, alu_ref(first_vec.a, first_vec.b, first_vec.op));
         chk("ff_actual", ffa, ffe | N'(1));
      end else begin
         chk("ff_valid_clean", ffv, 0);
      end
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fail_count", fcount, 0);
      chk("rst_vector", {srca, srcb, ctl}, 0);

      run(0, 1'b1);
      run(1, 1'b0);

      // reset mid-run, then a fresh run must repeat the same sequence
      fault = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (39) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_fail_count", fcount, 0);
      chk("mid_rst_src", {srca, srcb}, 0);
      chk("mid_rst_sat_count", fcount2, 0);
      run(1, 1'b0);

      // start coincident with reset: reset wins
      @(negedge clk); start = 1'b1; reset = 1'b1;
      @(negedge clk); start = 1'b0; reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_rst_busy", busy, 0);
      chk("start_rst_done", done, 0);
      chk("start_rst_src", {srca, srcb, ctl}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
